// File: rtl/led_cmd_pwm_pkg.sv
// led_cmd_pkg: command byte codes and parser state encoding for led_cmd_pwm
package led_cmd_pkg;
    localparam logic [7:0] CMD_R      = 8'd82;
    localparam logic [7:0] CMD_G      = 8'd71;
    localparam logic [7:0] CMD_B      = 8'd66;
    localparam logic [7:0] CMD_F      = 8'd70;
    localparam logic [7:0] CMD_X      = 8'd88;
    localparam logic [7:0] CMD_L      = 8'd76;
    localparam logic [7:0] CMD_DIGIT0 = 8'h30;
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_GET_CH   = 2'd1;
    localparam logic [1:0] S_GET_LVL  = 2'd2;
endpackage

// File: rtl/led_cmd_pwm_slice.sv
// pwm_slice: one LED channel; shadow/active duty, compare against shared counter, registered pin
//   Clock, Reset_n : clock, async active-low reset
//   cnt, wrap      : shared PWM counter and its all-ones (wrap) flag
//   en             : channel enable
//   wr, lvl        : shadow duty write strobe and value
//   led            : registered, polarity-corrected LED drive
module pwm_slice #(
    parameter int PWM_BITS   = 8,
    parameter bit ACTIVE_LOW = 1
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic [PWM_BITS-1:0] cnt,
    input  logic                wrap,
    input  logic                en,
    input  logic                wr,
    input  logic [PWM_BITS-1:0] lvl,
    output logic                led
);
    logic [PWM_BITS-1:0] shadow, active;
    logic on;
    // all-ones duty is treated as solid on so the last counter step has no gap
    assign on = en && (cnt < active || &active);
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            shadow <= '1;
            active <= '1;
            led    <= ACTIVE_LOW;
        end else begin
            shadow <= wr ? lvl : shadow;
            // a write landing on the wrap cycle bypasses the shadow
            active <= wrap ? (wr ? lvl : shadow) : active;
            led    <= on ^ ACTIVE_LOW;
        end
    end
endmodule

// File: rtl/led_cmd_pwm.sv
// led_cmd_pwm: byte-command driven multi-channel LED enable/brightness controller with PWM outputs
//   Clock, Reset_n   : clock, async active-low reset
//   Cmd, Cmd_Valid   : command/data byte and its per-cycle valid strobe
//   Led              : registered PWM drive per channel
//   Enable           : per-channel enable state
//   Busy             : parser inside an 'L' sequence
//   Err              : one-cycle pulse on bad channel index or timeout
module led_cmd_pwm
    import led_cmd_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int PWM_BITS    = 8,
    parameter int CMD_W       = 8,
    parameter bit ACTIVE_LOW  = 1,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic [CMD_W-1:0]  Cmd,
    input  logic              Cmd_Valid,
    output logic [NUM_CH-1:0] Led,
    output logic [NUM_CH-1:0] Enable,
    output logic              Busy,
    output logic              Err
);
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int TW   = TIMEOUT_CYC > 2 ? $clog2(TIMEOUT_CYC) : 1;
    logic [1:0]          state;
    logic [CH_W-1:0]     ch;
    logic [TW-1:0]       tmo;
    logic [PWM_BITS-1:0] cnt, lvl;
    logic [NUM_CH-1:0]   tog, wr;
    logic                idle_v, tmo_hit, ch_ok, wrap;
    assign idle_v  = Cmd_Valid && state == S_IDLE;
    assign tmo_hit = state != S_IDLE && !Cmd_Valid && tmo == TW'(TIMEOUT_CYC - 1);
    assign ch_ok   = Cmd < CMD_W'(NUM_CH);
    assign lvl     = PWM_BITS'(Cmd);
    assign wrap    = &cnt;
    assign Busy    = state != S_IDLE;
    // channels >= NUM_CH have no bit here, so their codes fall out as ignored
    always_comb begin
        tog = '0;
        wr  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            tog[i] = Cmd == CMD_W'(CMD_DIGIT0 + i) || (i == 0 && Cmd == CMD_W'(CMD_R))
                  || (i == 1 && Cmd == CMD_W'(CMD_G)) || (i == 2 && Cmd == CMD_W'(CMD_B));
            wr[i]  = state == S_GET_LVL && Cmd_Valid && ch == CH_W'(i);
        end
    end
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= S_IDLE;
            ch     <= '0;
            tmo    <= '0;
            Err    <= 1'b0;
            Enable <= '0;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            Err <= 1'b0;
            if (idle_v)
                Enable <= Cmd == CMD_W'(CMD_F) ? '1 : Cmd == CMD_W'(CMD_X) ? '0 : Enable ^ tog;
            tmo <= (state == S_IDLE || Cmd_Valid || tmo_hit) ? '0 : tmo + 1'b1;
            if (tmo_hit) begin
                state <= S_IDLE;
                Err   <= 1'b1;
            end else if (Cmd_Valid) begin
                case (state)
                    S_IDLE:   if (Cmd == CMD_W'(CMD_L)) state <= S_GET_CH;
                    S_GET_CH: begin
                        if (ch_ok) begin
                            ch    <= CH_W'(Cmd);
                            state <= S_GET_LVL;
                        end else begin
                            Err   <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                    default:  state <= S_IDLE;
                endcase
            end
        end
    end
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_slice #(.PWM_BITS(PWM_BITS), .ACTIVE_LOW(ACTIVE_LOW)) u_slice (
            .Clock  (Clock),
            .Reset_n(Reset_n),
            .cnt    (cnt),
            .wrap   (wrap),
            .en     (Enable[g]),
            .wr     (wr[g]),
            .lvl    (lvl),
            .led    (Led[g])
        );
    end
endmodule

// File: tb/tb_led_cmd_pwm.sv
// tb_led_cmd_pwm: directed self-checking bench for led_cmd_pwm (NUM_CH=3, 8-bit PWM, active-low, timeout 16)
module tb_led_cmd_pwm;
    logic       Clock = 1'b0;
    logic       Reset_n = 1'b0;
    logic [7:0] Cmd = 8'h00;
    logic       Cmd_Valid = 1'b0;
    logic [2:0] Led, Enable;
    logic       Busy, Err;
    int total = 0;
    int bad = 0;
    logic [7:0] pc;
    led_cmd_pwm #(.NUM_CH(3), .PWM_BITS(8), .CMD_W(8), .ACTIVE_LOW(1), .TIMEOUT_CYC(16)) dut (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .Cmd      (Cmd),
        .Cmd_Valid(Cmd_Valid),
        .Led      (Led),
        .Enable   (Enable),
        .Busy     (Busy),
        .Err      (Err)
    );
    always #5 Clock = ~Clock;
    // reference PWM phase: free-running 8-bit count from reset release
    always @(posedge Clock or negedge Reset_n)
        if (!Reset_n) pc <= 8'd0;
        else pc <= pc + 8'd1;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(posedge Clock);
        #1;
    endtask
    task automatic send(input logic [7:0] b);
        Cmd = b;
        Cmd_Valid = 1'b1;
        tick();
        Cmd_Valid = 1'b0;
    endtask
    initial begin
        int lows, other, early;
        logic at64, at65;
        repeat (3) tick();
        chk("rst_led", Led, 3'b111);
        chk("rst_en", Enable, 3'b000);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_err", Err, 1'b0);
        Reset_n = 1'b1;
        tick();
        // 1: R then B
        send(8'd82);
        send(8'd66);
        chk("t1_en", Enable, 3'b101);
        chk("t1_led_lat", Led, 3'b110);
        other = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (Led !== 3'b010) other++;
        end
        chk("t1_led_steady", other, 0);
        // 2: F, L 1 0x40
        send(8'd70);
        send(8'd76);
        chk("t2_busy", Busy, 1'b1);
        send(8'h01);
        send(8'h40);
        chk("t2_busy_done", Busy, 1'b0);
        chk("t2_en", Enable, 3'b111);
        do tick(); while (pc != 8'd1);
        lows = 0; other = 0; at64 = 1'bx; at65 = 1'bx;
        for (int i = 0; i < 256; i++) begin
            if (Led[1] === 1'b0) lows++;
            if (Led[0] !== 1'b0 || Led[2] !== 1'b0) other++;
            if (pc == 8'd64) at64 = Led[1];
            if (pc == 8'd65) at65 = Led[1];
            tick();
        end
        chk("t2_lows", lows, 64);
        chk("t2_ch02_on", other, 0);
        chk("t2_last_on", at64, 1'b0);
        chk("t2_first_off", at65, 1'b1);
        // 3: bad channel index
        send(8'd76);
        send(8'h05);
        chk("t3_err", Err, 1'b1);
        chk("t3_busy", Busy, 1'b0);
        tick();
        chk("t3_err_pulse", Err, 1'b0);
        send(8'd71);
        chk("t3_en", Enable, 3'b101);
        // 4: timeout after 16 idle cycles
        send(8'd76);
        chk("t4_busy", Busy, 1'b1);
        early = 0;
        for (int i = 1; i < 16; i++) begin
            tick();
            if (Err !== 1'b0) early++;
        end
        chk("t4_no_early_err", early, 0);
        tick();
        chk("t4_err", Err, 1'b1);
        chk("t4_idle", Busy, 1'b0);
        tick();
        chk("t4_err_pulse", Err, 1'b0);
        send(8'h02);
        chk("t4_ignored_en", Enable, 3'b101);
        chk("t4_ignored_busy", Busy, 1'b0);
        // 5: async reset mid-sequence
        send(8'd70);
        send(8'd76);
        send(8'h00);
        chk("t5_busy", Busy, 1'b1);
        #2 Reset_n = 1'b0;
        #1;
        chk("t5_led", Led, 3'b111);
        chk("t5_en", Enable, 3'b000);
        chk("t5_busy_rst", Busy, 1'b0);
        tick();
        Reset_n = 1'b1;
        send(8'd70);
        other = 0;
        for (int i = 0; i < 260; i++) begin
            tick();
            if (Led !== 3'b000) other++;
        end
        chk("t5_duty_full", other, 0);
        // 6: level 0 on channel 0 written on the wrap cycle
        for (int i = 0; i < 300 && pc != 8'd253; i++) tick();
        send(8'd76);
        send(8'h00);
        send(8'h00);
        lows = 0; other = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (Led[0] !== 1'b1) lows++;
            if (Led[2:1] !== 2'b00) other++;
        end
        chk("t6_ch0_off", lows, 0);
        chk("t6_ch12_on", other, 0);
        send(8'd88);
        send(8'h30);
        chk("t6_en", Enable, 3'b001);
        tick();
        chk("t6_led", Led, 3'b111);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
